// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - programmable branch-target table with registered lookup
// After reset an INIT sweep clears the array; lookups and writes are only honoured in RUN.
module branch_target_table #(
  parameter int D  = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [D-1:0]  req_pc,
  output logic          resp_valid,
  output logic [D-1:0]  resp_target,
  output logic          resp_hit,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_rel,
  output logic          busy
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx;

  logic          ent_valid [DEPTH];
  logic          ent_rel   [DEPTH];
  logic [D-1:0]  ent_data  [DEPTH];

  logic          accept;
  logic          bypass;
  logic          sel_valid;
  logic          sel_rel;
  logic [D-1:0]  sel_data;
  logic [D-1:0]  tgt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    req_ready = 1'b0;
    case (state)
      INIT: if (idx == {AW{1'b1}}) state_nxt = RUN;
      RUN: begin
        busy      = 1'b0;
        req_ready = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              idx <= '0;
    else if (state == INIT) idx <= idx + AW'(1);
  end

  // Storage has no reset: the sweep owns it during INIT, writers own it in RUN.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      ent_valid[idx] <= 1'b0;
      ent_rel[idx]   <= 1'b0;
      ent_data[idx]  <= '0;
    end else if (wr_en) begin
      ent_valid[wr_addr] <= 1'b1;
      ent_rel[wr_addr]   <= wr_rel;
      ent_data[wr_addr]  <= wr_data;
    end
  end

  assign accept = req_valid && req_ready;
  assign bypass = wr_en && (wr_addr == req_addr);

  // Same-index write in the lookup cycle is forwarded so the response sees the new entry.
  always_comb begin
    sel_valid = ent_valid[req_addr];
    sel_rel   = ent_rel[req_addr];
    sel_data  = ent_data[req_addr];
    if (bypass) begin
      sel_valid = 1'b1;
      sel_rel   = wr_rel;
      sel_data  = wr_data;
    end
    tgt_nxt = sel_data;
    if (!sel_valid)   tgt_nxt = req_pc + D'(1);
    else if (sel_rel) tgt_nxt = req_pc + sel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_target <= '0;
      resp_hit    <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_target <= tgt_nxt;
        resp_hit    <= sel_valid;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// tb/tb_branch_target_table.sv - directed self-checking bench for branch_target_table
module tb_branch_target_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [9:0] req_pc;
  logic       resp_valid;
  logic [9:0] resp_target;
  logic       resp_hit;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic       wr_rel;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int n;

  branch_target_table #(.D(10), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_target(resp_target), .resp_hit(resp_hit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rel(wr_rel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [9:0] d, input logic rel);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_rel = rel;
    step();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [3:0] a, input logic [9:0] pc,
                        input logic exp_hit, input logic [9:0] exp_tgt);
    req_valid = 1'b1; req_addr = a; req_pc = pc;
    step();
    req_valid = 1'b0;
    wr_en = 1'b0;
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_hit"}, resp_hit, exp_hit);
    check({tag, "_tgt"}, resp_target, exp_tgt);
  endtask

  task automatic count_busy();
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_pc = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_rel = 1'b0;
    step(); step();
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_rvalid", resp_valid, 0);
    check("rst_tgt", resp_target, 0);
    check("rst_hit", resp_hit, 0);

    // 1: sweep length, then a miss
    reset = 1'b0;
    count_busy();
    check("init_cycles", n, 16);
    check("run_ready", req_ready, 1);
    lookup("miss7", 4'd7, 10'd30, 1'b0, 10'd31);

    // 2: absolute entry, single-cycle pulse, hold
    write(4'd3, 10'd101, 1'b0);
    lookup("abs3", 4'd3, 10'd5, 1'b1, 10'd101);
    step();
    check("pulse_end", resp_valid, 0);
    check("hold_tgt", resp_target, 101);
    check("hold_hit", resp_hit, 1);

    // 3: relative entry with negative offset and wrap
    write(4'd4, 10'h3FB, 1'b1);
    lookup("rel4a", 4'd4, 10'd4, 1'b1, 10'h3FF);
    lookup("rel4b", 4'd4, 10'd20, 1'b1, 10'd15);
    lookup("misswrap", 4'd9, 10'h3FF, 1'b0, 10'd0);

    // 4: write bypass and non-interfering write
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 10'd43; wr_rel = 1'b0;
    lookup("byp2", 4'd2, 10'd0, 1'b1, 10'd43);
    write(4'd1, 10'd200, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 10'd55; wr_rel = 1'b0;
    lookup("other1", 4'd1, 10'd50, 1'b1, 10'd200);
    lookup("rewr2", 4'd2, 10'd0, 1'b1, 10'd55);
    write(4'd2, 10'd3, 1'b1);
    lookup("mode2", 4'd2, 10'd10, 1'b1, 10'd13);

    // 5: back-to-back responses in order
    req_valid = 1'b1; req_addr = 4'd3; req_pc = 10'd200;
    step();
    check("b2b0_valid", resp_valid, 1);
    check("b2b0_tgt", resp_target, 101);
    req_addr = 4'd4;
    step();
    check("b2b1_valid", resp_valid, 1);
    check("b2b1_tgt", resp_target, 195);
    req_addr = 4'd7;
    step();
    check("b2b2_valid", resp_valid, 1);
    check("b2b2_hit", resp_hit, 0);
    check("b2b2_tgt", resp_target, 201);
    req_valid = 1'b0;
    step();
    check("b2b_end", resp_valid, 0);

    // 6: reset during a lookup, writes ignored while sweeping
    req_valid = 1'b1; req_addr = 4'd3; req_pc = 10'd0;
    step();
    check("pre_rst_valid", resp_valid, 1);
    reset = 1'b1;
    #1;
    check("drop_valid", resp_valid, 0);
    check("drop_busy", busy, 1);
    check("drop_tgt", resp_target, 0);
    req_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 10'd7; wr_rel = 1'b0;
    count_busy();
    wr_en = 1'b0;
    check("reinit_cycles", n, 16);
    lookup("post3", 4'd3, 10'd8, 1'b0, 10'd9);
    lookup("post4", 4'd4, 10'd100, 1'b0, 10'd101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
